// File: rtl/cu_pkg.sv
// Shared encodings for the control unit / datapath interface: write sources,
// ALU opcodes and the fixed operand/result register indices.
package cu_pkg;

   localparam logic [2:0] SRC_READBACK = 3'd0;
   localparam logic [2:0] SRC_DATA_IN  = 3'd1;
   localparam logic [2:0] SRC_CONST    = 3'd2;
   localparam logic [2:0] SRC_ALU      = 3'd3;

   localparam logic [1:0] OP_ADD  = 2'd0;
   localparam logic [1:0] OP_XOR  = 2'd1;
   localparam logic [1:0] OP_SUB  = 2'd2;
   localparam logic [1:0] OP_PASS = 2'd3;

   localparam logic [3:0] OPA_REG = 4'd1;
   localparam logic [3:0] OPB_REG = 4'd2;
   localparam logic [3:0] RES_REG = 4'd0;

endpackage

// File: rtl/cu_alu.sv
// Combinational 2-bit-opcode ALU: ADD/XOR/SUB/PASS with carry-or-borrow and
// zero outputs.
module cu_alu
   import cu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] y,
   output logic             c,
   output logic             zero
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   assign sum  = {1'b0, a} + {1'b0, b};
   // Top bit of the widened difference is set exactly when a < b.
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      y = a;
      c = 1'b0;
      unique case (op)
         OP_ADD: begin
            y = sum[WIDTH-1:0];
            c = sum[WIDTH];
         end
         OP_XOR: y = a ^ b;
         OP_SUB: begin
            y = diff[WIDTH-1:0];
            c = diff[WIDTH];
         end
         OP_PASS: y = a;
      endcase
   end

   assign zero = (y == '0);

endmodule

// File: rtl/cu_datapath.sv
// Datapath behind the control unit: register file, write-source mux, ALU flags,
// bypassed registered read port and end-of-program capture of R0.
module cu_datapath
   import cu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREGS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [1:0]       ins_sel,
   input  logic [2:0]       in_mux_add,
   input  logic [3:0]       reg_add,
   input  logic [3:0]       out_mux_add,
   input  logic [WIDTH-1:0] cu_const,
   input  logic [WIDTH-1:0] data_in,
   input  logic             busy,
   output logic             co,
   output logic             z,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] result,
   output logic             result_valid
);

   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] alu_y;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata;
   logic             alu_c;
   logic             alu_zero;
   logic             alu_write;
   logic             busy_q;
   logic             busy_fall;

   cu_alu #(
      .WIDTH(WIDTH)
   ) u_alu (
      .a   (regs[OPA_REG]),
      .b   (regs[OPB_REG]),
      .op  (ins_sel),
      .y   (alu_y),
      .c   (alu_c),
      .zero(alu_zero)
   );

   assign rdata = regs[out_mux_add];

   always_comb begin
      wdata = '0;
      case (in_mux_add)
         SRC_READBACK: wdata = rdata;
         SRC_DATA_IN:  wdata = data_in;
         SRC_CONST:    wdata = cu_const;
         SRC_ALU:      wdata = alu_y;
         default:      wdata = '0;
      endcase
   end

   assign alu_write = we && (in_mux_add == SRC_ALU);
   assign busy_fall = busy_q && !busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         co           <= 1'b0;
         z            <= 1'b0;
         data_out     <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         if (we) regs[reg_add] <= wdata;
         if (alu_write) begin
            co <= alu_c;
            z  <= alu_zero;
         end
         data_out     <= (we && reg_add == out_mux_add) ? wdata : rdata;
         busy_q       <= busy;
         result_valid <= busy_fall;
         // The CU's final state may itself write R0; capture that new value.
         if (busy_fall) result <= (we && reg_add == RES_REG) ? wdata : regs[RES_REG];
      end
   end

endmodule

// File: tb/tb_cu_datapath.sv
// Self-checking bench for cu_datapath: a spec-level reference model pushes the
// expected outputs per cycle to a scoreboard that is popped after each edge.
module tb_cu_datapath;
   import cu_pkg::*;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             we;
   logic [1:0]       ins_sel;
   logic [2:0]       in_mux_add;
   logic [3:0]       reg_add;
   logic [3:0]       out_mux_add;
   logic [WIDTH-1:0] cu_const;
   logic [WIDTH-1:0] data_in;
   logic             busy;
   logic             co;
   logic             z;
   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] result;
   logic             result_valid;

   cu_datapath #(
      .WIDTH(WIDTH),
      .NREGS(16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .we          (we),
      .ins_sel     (ins_sel),
      .in_mux_add  (in_mux_add),
      .reg_add     (reg_add),
      .out_mux_add (out_mux_add),
      .cu_const    (cu_const),
      .data_in     (data_in),
      .busy        (busy),
      .co          (co),
      .z           (z),
      .data_out    (data_out),
      .result      (result),
      .result_valid(result_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] dout;
      logic             co;
      logic             z;
      logic [WIDTH-1:0] res;
      logic             rv;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [WIDTH-1:0] m_regs [16];
   logic             m_co;
   logic             m_z;
   logic             m_busy_q;
   logic [WIDTH-1:0] m_res;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_co     = 1'b0;
      m_z      = 1'b0;
      m_busy_q = 1'b0;
      m_res    = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_co"}, 32'(co), 32'd0);
      check_eq({tag, "_z"}, 32'(z), 32'd0);
      check_eq({tag, "_data_out"}, 32'(data_out), 32'd0);
      check_eq({tag, "_result"}, 32'(result), 32'd0);
      check_eq({tag, "_result_valid"}, 32'(result_valid), 32'd0);
   endtask

   // One clock: drive inputs, predict outputs, compare after the edge.
   task automatic cycle(input logic w, input logic [1:0] op, input logic [2:0] src,
                        input logic [3:0] ra, input logic [3:0] oa,
                        input logic [WIDTH-1:0] k, input logic [WIDTH-1:0] din,
                        input logic bsy);
      logic [WIDTH-1:0] a, b, y, wd;
      logic [WIDTH:0]   s;
      logic             c;
      exp_t             e;
      we = w; ins_sel = op; in_mux_add = src; reg_add = ra; out_mux_add = oa;
      cu_const = k; data_in = din; busy = bsy;
      a = m_regs[1];
      b = m_regs[2];
      case (op)
         2'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[WIDTH-1:0]; c = s[WIDTH]; end
         2'd1: begin y = a ^ b; c = 1'b0; end
         2'd2: begin y = a - b; c = (a < b); end
         default: begin y = a; c = 1'b0; end
      endcase
      case (src)
         3'd0: wd = m_regs[oa];
         3'd1: wd = din;
         3'd2: wd = k;
         3'd3: wd = y;
         default: wd = '0;
      endcase
      e.dout = (w && ra == oa) ? wd : m_regs[oa];
      if (w && src == 3'd3) begin
         m_co = c;
         m_z  = (y == '0);
      end
      e.rv = m_busy_q && !bsy;
      if (e.rv) m_res = (w && ra == 4'd0) ? wd : m_regs[0];
      e.co  = m_co;
      e.z   = m_z;
      e.res = m_res;
      if (w) m_regs[ra] = wd;
      m_busy_q = bsy;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_eq("sb_data_out", 32'(data_out), 32'(e.dout));
      check_eq("sb_co", 32'(co), 32'(e.co));
      check_eq("sb_z", 32'(z), 32'(e.z));
      check_eq("sb_result", 32'(result), 32'(e.res));
      check_eq("sb_result_valid", 32'(result_valid), 32'(e.rv));
   endtask

   task automatic idle(input logic bsy, input logic [3:0] oa);
      cycle(1'b0, 2'd0, 3'd0, 4'd0, oa, 8'h00, 8'h00, bsy);
   endtask

   // Asynchronous reset pulse between clock edges.
   task automatic mid_reset(input string tag);
      #2;
      reset = 1'b1;
      we    = 1'b0;
      busy  = 1'b0;
      #1;
      check_all_zero(tag);
      model_reset();
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; we = 1'b0; ins_sel = '0; in_mux_add = '0; reg_add = '0;
      out_mux_add = '0; cu_const = '0; data_in = '0; busy = 1'b0;
      model_reset();
      #12;
      check_all_zero("por");
      reset = 1'b0;

      // Reset clears written state.
      cycle(1'b1, OP_ADD, SRC_DATA_IN, 4'd5, 4'd0, 8'h00, 8'h3C, 1'b0);
      idle(1'b0, 4'd5);
      check_eq("r5_before_reset", 32'(data_out), 32'h3C);
      mid_reset("mid_reset");
      idle(1'b0, 4'd5);
      check_eq("r5_after_reset", 32'(data_out), 32'h00);

      // ADD with carry out.
      cycle(1'b1, OP_ADD, SRC_DATA_IN, 4'd1, 4'd0, 8'h00, 8'hF0, 1'b0);
      cycle(1'b1, OP_ADD, SRC_DATA_IN, 4'd2, 4'd0, 8'h00, 8'h20, 1'b0);
      cycle(1'b1, OP_ADD, SRC_ALU, 4'd3, 4'd0, 8'h00, 8'h00, 1'b0);
      check_eq("add_co", 32'(co), 32'd1);
      check_eq("add_z", 32'(z), 32'd0);
      idle(1'b0, 4'd3);
      check_eq("add_r3", 32'(data_out), 32'h10);

      // SUB with borrow, then zero result, then non-ALU write holds flags.
      cycle(1'b1, OP_ADD, SRC_DATA_IN, 4'd1, 4'd0, 8'h00, 8'h05, 1'b0);
      cycle(1'b1, OP_ADD, SRC_DATA_IN, 4'd2, 4'd0, 8'h00, 8'h07, 1'b0);
      cycle(1'b1, OP_SUB, SRC_ALU, 4'd4, 4'd4, 8'h00, 8'h00, 1'b0);
      check_eq("sub_borrow_r4", 32'(data_out), 32'hFE);
      check_eq("sub_borrow_co", 32'(co), 32'd1);
      check_eq("sub_borrow_z", 32'(z), 32'd0);
      cycle(1'b1, OP_ADD, SRC_DATA_IN, 4'd2, 4'd0, 8'h00, 8'h05, 1'b0);
      cycle(1'b1, OP_SUB, SRC_ALU, 4'd4, 4'd4, 8'h00, 8'h00, 1'b0);
      check_eq("sub_zero_r4", 32'(data_out), 32'h00);
      check_eq("sub_zero_co", 32'(co), 32'd0);
      check_eq("sub_zero_z", 32'(z), 32'd1);
      cycle(1'b1, OP_ADD, SRC_CONST, 4'd7, 4'd0, 8'h5A, 8'h00, 1'b0);
      check_eq("const_hold_co", 32'(co), 32'd0);
      check_eq("const_hold_z", 32'(z), 32'd1);

      // XOR, PASS and read-modify-write of R1.
      cycle(1'b1, OP_XOR, SRC_ALU, 4'd8, 4'd0, 8'h00, 8'h00, 1'b0);
      cycle(1'b1, OP_PASS, SRC_ALU, 4'd9, 4'd9, 8'h00, 8'h00, 1'b0);
      cycle(1'b1, OP_ADD, SRC_ALU, 4'd1, 4'd1, 8'h00, 8'h00, 1'b0);
      check_eq("rmw_r1", 32'(data_out), 32'h0A);
      cycle(1'b1, OP_ADD, SRC_READBACK, 4'd10, 4'd7, 8'h00, 8'h00, 1'b0);
      cycle(1'b1, OP_ADD, 3'd5, 4'd11, 4'd11, 8'h00, 8'h33, 1'b0);

      // Read bypass.
      cycle(1'b1, OP_ADD, SRC_DATA_IN, 4'd6, 4'd0, 8'h00, 8'h11, 1'b0);
      cycle(1'b1, OP_ADD, SRC_CONST, 4'd6, 4'd6, 8'hA5, 8'h00, 1'b0);
      check_eq("bypass_r6", 32'(data_out), 32'hA5);

      // CU-like program: busy 10 cycles, final state writes R0 = 9 - 3.
      cycle(1'b1, OP_ADD, SRC_DATA_IN, 4'd1, 4'd0, 8'h00, 8'h09, 1'b1);
      cycle(1'b1, OP_ADD, SRC_DATA_IN, 4'd2, 4'd0, 8'h00, 8'h03, 1'b1);
      for (int i = 0; i < 8; i++) idle(1'b1, 4'(i));
      cycle(1'b1, OP_SUB, SRC_ALU, 4'd0, 4'd0, 8'h00, 8'h00, 1'b0);
      check_eq("prog_result", 32'(result), 32'h06);
      check_eq("prog_valid", 32'(result_valid), 32'd1);
      idle(1'b0, 4'd0);
      check_eq("prog_valid_drop", 32'(result_valid), 32'd0);
      check_eq("prog_result_hold", 32'(result), 32'h06);

      // Reset during busy aborts; next program pulses once.
      cycle(1'b1, OP_ADD, SRC_DATA_IN, 4'd0, 4'd0, 8'h00, 8'h44, 1'b1);
      idle(1'b1, 4'd0);
      mid_reset("busy_reset");
      idle(1'b0, 4'd0);
      check_eq("abort_no_pulse", 32'(result_valid), 32'd0);
      idle(1'b0, 4'd0);
      cycle(1'b1, OP_ADD, SRC_DATA_IN, 4'd0, 4'd0, 8'h00, 8'h77, 1'b1);
      idle(1'b1, 4'd0);
      idle(1'b0, 4'd0);
      check_eq("rerun_result", 32'(result), 32'h77);
      check_eq("rerun_valid", 32'(result_valid), 32'd1);
      idle(1'b0, 4'd0);
      check_eq("rerun_valid_drop", 32'(result_valid), 32'd0);

      // One-cycle busy glitch and back-to-back programs.
      cycle(1'b1, OP_ADD, SRC_CONST, 4'd0, 4'd0, 8'h21, 8'h00, 1'b1);
      idle(1'b0, 4'd0);
      check_eq("glitch_result", 32'(result), 32'h21);
      cycle(1'b1, OP_ADD, SRC_CONST, 4'd0, 4'd0, 8'h42, 8'h00, 1'b1);
      cycle(1'b1, OP_ADD, SRC_CONST, 4'd0, 4'd0, 8'h43, 8'h00, 1'b0);
      check_eq("b2b_result", 32'(result), 32'h43);
      idle(1'b1, 4'd0);
      idle(1'b0, 4'd0);
      idle(1'b0, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
